div_unit: RTL and testbench

Multi-cycle unsigned divider for the EX stage, the inverse of the ALU's add/subtract path. It performs 32-bit restoring division, one quotient bit per cycle, using a trial subtract. Results go to HI (remainder) and LO (quotient). The hazard unit stalls the pipeline while `busy` is high.

---
 rtl/div_unit_pkg.sv | 17 +
 rtl/div_unit_step.sv | 28 ++
 rtl/div_unit.sv | 109 ++++++++++
 tb/tb_div_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the EX-stage divider.
//   - 6-bit function codes seen on the ID/EX function field
//   - divider FSM state encoding
package div_unit_pkg;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_DIVU = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// div_step: one restoring-division iteration (combinational).
//   rem      in  WIDTH : current partial remainder (always < divisor)
//   quo_msb  in  1     : quotient-register MSB shifted into the remainder
//   divisor  in  WIDTH : latched divisor
//   rem_next out WIDTH : remainder after the trial subtract
//   q_bit    out 1     : quotient bit produced this iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             quo_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Because rem < divisor, the shifted value is < 2*divisor. A successful
    // subtract therefore leaves a result below 2^WIDTH, while a failed one
    // wraps to at least 2^WIDTH, so diff[WIDTH] acts as the borrow.
    assign shifted  = {rem, quo_msb};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk      in  1     : clock, rising edge
//   rst_n    in  1     : asynchronous active-low reset
//   start    in  1     : launch request, qualified by Signal == DIVU
//   Signal   in  6     : function field from ID/EX
//   dividend in  WIDTH : unsigned numerator
//   divisor  in  WIDTH : unsigned denominator
//   busy     out 1     : unit occupied; launches ignored
//   done     out 1     : one-cycle pulse, lo/hi valid
//   lo       out WIDTH : quotient (all ones on divide by zero)
//   hi       out WIDTH : remainder (dividend on divide by zero)
module div_unit
    import div_unit_pkg::*;
#(
    parameter int         WIDTH = 32,
    parameter logic [5:0] DIVU  = FN_DIVU
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int               CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    div_state_t       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] hi_reg;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] quo_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .quo_msb  (quo_reg[WIDTH-1]),
        .divisor  (dsr_reg),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // The dividend sits in quo_reg and is shifted out MSB-first while the
    // quotient bits fill in from the LSB.
    assign quo_next = {quo_reg[WIDTH-2:0], q_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dsr_reg   <= '0;
            lo_reg    <= '0;
            hi_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && Signal == DIVU) begin
                        if (divisor == '0) begin
                            // Divide by zero resolves immediately.
                            lo_reg    <= '1;
                            hi_reg    <= dividend;
                            state_reg <= ST_DONE;
                        end else begin
                            rem_reg   <= '0;
                            quo_reg   <= dividend;
                            dsr_reg   <= divisor;
                            count_reg <= '0;
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    rem_reg   <= rem_next;
                    quo_reg   <= quo_next;
                    count_reg <= count_reg + CNT_W'(1);
                    if (count_reg == LAST) begin
                        lo_reg    <= quo_next;
                        hi_reg    <= rem_next;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);
    assign lo   = lo_reg;
    assign hi   = hi_reg;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. The driver pushes the expected
// quotient/remainder (plain / and % arithmetic) when it launches a divide; a
// monitor pops and compares on every done pulse.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   sig = 6'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] lo;
    logic [W-1:0] hi;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .Signal   (sig),
        .dividend (a),
        .divisor  (b),
        .busy     (busy),
        .done     (done),
        .lo       (lo),
        .hi       (hi)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.a = x;
        e.b = y;
        if (y == 0) begin
            e.q = '1;
            e.r = x;
        end else begin
            e.q = x / y;
            e.r = x % y;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding launch.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got lo=0x%0h hi=0x%0h, expected no result", lo, hi);
            end else begin
                mon_e = sb.pop_front();
                $display("txn 0x%08h / 0x%08h -> lo=0x%08h hi=0x%08h (exp 0x%08h 0x%08h)",
                         mon_e.a, mon_e.b, lo, hi, mon_e.q, mon_e.r);
                check("lo", lo, mon_e.q);
                check("hi", hi, mon_e.r);
            end
        end
    end

    // Present a request for one clock; returns #1 after the sampling edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [5:0] f, input bit push);
        @(negedge clk);
        a = x;
        b = y;
        sig = f;
        start = 1'b1;
        if (push) sb.push_back(model(x, y));
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Wait (bounded) for done; lat counts edges after the launch edge.
    task automatic wait_done(output int lat, output int busy_gaps);
        lat = 0;
        busy_gaps = 0;
        while (!done && lat < 60) begin
            if (!busy) busy_gaps++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", lat);
        end
    endtask

    // Launch a divide, check latency, then check the unit frees itself.
    task automatic run_div(input logic [W-1:0] x, input logic [W-1:0] y);
        int lat;
        int gaps;
        issue(x, y, FN_DIVU, 1'b1);
        check("busy_after_launch", busy, 1);
        wait_done(lat, gaps);
        check("latency", lat, (y == 0) ? 0 : 32);
        check("busy_gaps", gaps, 0);
        @(posedge clk);
        #1;
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int lat;
        int gaps;
        int d0;
        logic [W-1:0] x;
        logic [W-1:0] y;

        // Reset state
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lo", lo, 0);
        check("rst_hi", hi, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_div(32'd100, 32'd7);
        run_div(32'hFFFF_FFFF, 32'd1);
        run_div(32'd5, 32'hFFFF_FFFF);      // launched the cycle after done
        run_div(32'd5, 32'd0);

        // Non-DIVU function code must not launch
        d0 = done_cnt;
        issue(32'd9, 32'd3, FN_ADD, 1'b0);
        check("add_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("add_busy_later", busy, 0);
        check("add_no_done", done_cnt, d0);

        // A second start mid-run is ignored
        issue(32'd1000000, 32'd13, FN_DIVU, 1'b1);
        repeat (9) @(posedge clk);
        issue(32'd77, 32'd2, FN_DIVU, 1'b0);
        wait_done(lat, gaps);
        check("midrun_latency", lat, 22);
        @(posedge clk);
        #1;

        // Reset mid-run aborts
        d0 = done_cnt;
        issue(32'd1000, 32'd3, FN_DIVU, 1'b1);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_lo", lo, 0);
        check("abort_hi", hi, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, d0);
        run_div(32'd1000, 32'd3);

        // Randomized divides
        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            if ($urandom_range(0, 3) == 0) x = W'($urandom_range(0, 1000));
            case ($urandom_range(0, 9))
                0:       y = '0;
                1, 2, 3: y = W'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) begin
                issue(x, y, FN_SUB, 1'b0);
                check("rand_nondivu_busy", busy, 0);
            end else begin
                run_div(x, y);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
